// File: rtl/cia_pkg.sv
// cia_pkg: CIA register map, arbiter FSM states and default host block masks
package cia_pkg;
  localparam logic [3:0] CIA_PRA    = 4'h0;
  localparam logic [3:0] CIA_PRB    = 4'h1;
  localparam logic [3:0] CIA_DDRA   = 4'h2;
  localparam logic [3:0] CIA_DDRB   = 4'h3;
  localparam logic [3:0] CIA_TALO   = 4'h4;
  localparam logic [3:0] CIA_TAHI   = 4'h5;
  localparam logic [3:0] CIA_TBLO   = 4'h6;
  localparam logic [3:0] CIA_TBHI   = 4'h7;
  localparam logic [3:0] CIA_TOD10  = 4'h8;
  localparam logic [3:0] CIA_TODSEC = 4'h9;
  localparam logic [3:0] CIA_TODMIN = 4'hA;
  localparam logic [3:0] CIA_TODHR  = 4'hB;
  localparam logic [3:0] CIA_SDR    = 4'hC;
  localparam logic [3:0] CIA_ICR    = 4'hD;
  localparam logic [3:0] CIA_CRA    = 4'hE;
  localparam logic [3:0] CIA_CRB    = 4'hF;
  // PRB (pc_n strobe), TOD 10ths/hours (latch), SDR and ICR (clear on read)
  localparam logic [15:0] RD_BLOCK_DEF = 16'h3902;
  localparam logic [15:0] WR_BLOCK_DEF = 16'h0000;
  typedef enum logic [1:0] {IDLE, CPU_SLOT, HOST_SLOT, HOST_CAPT} arb_state_t;
  function automatic logic host_refused(input logic [15:0] rd_mask, input logic [15:0] wr_mask,
                                        input logic we, input logic [3:0] rs);
    return we ? wr_mask[rs] : rd_mask[rs];
  endfunction
endpackage

// File: rtl/cia_bus_arbiter.sv
// cia_bus_arbiter: shares one CIA between the CPU bus and a host port, CPU first, host in idle phi2 slots
module cia_bus_arbiter
  import cia_pkg::*;
#(
  parameter logic [15:0] RD_BLOCK_MASK = RD_BLOCK_DEF,
  parameter logic [15:0] WR_BLOCK_MASK = WR_BLOCK_DEF
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       phi2_p,
  input  logic       phi2_n,
  input  logic       cpu_cs_n,
  input  logic       cpu_rw,
  input  logic [3:0] cpu_rs,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [3:0] host_rs,
  input  logic [7:0] host_din,
  output logic [7:0] host_dout,
  output logic       host_ack,
  output logic       host_err,
  output logic       cia_cs_n,
  output logic       cia_rw,
  output logic [3:0] cia_rs,
  output logic [7:0] cia_db_in,
  input  logic [7:0] cia_db_out
);
  arb_state_t state;
  logic       pend;
  logic       fall_seen;
  logic       h_we;
  logic [3:0] h_rs;
  logic [7:0] h_din;
  logic       take;
  logic       refuse;
  // a new host request is only considered when nothing is pending and no ack is on the wire
  always_comb begin
    take   = host_req && !pend && !host_ack;
    refuse = host_refused(RD_BLOCK_MASK, WR_BLOCK_MASK, host_we, host_rs);
  end
  // slot sequencer: grant at phi2_p, hold through phi2_n, release one clk later
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= IDLE;
      pend      <= 1'b0;
      fall_seen <= 1'b0;
      h_we      <= 1'b0;
      h_rs      <= '0;
      h_din     <= '0;
      cia_cs_n  <= 1'b1;
      cia_rw    <= 1'b1;
      cia_rs    <= '0;
      cia_db_in <= '0;
      cpu_dout  <= '0;
      host_dout <= '0;
      host_ack  <= 1'b0;
      host_err  <= 1'b0;
    end else begin
      host_ack <= 1'b0;
      host_err <= 1'b0;
      if (take && refuse) begin
        host_ack <= 1'b1;
        host_err <= 1'b1;
      end else if (take) begin
        pend  <= 1'b1;
        h_we  <= host_we;
        h_rs  <= host_rs;
        h_din <= host_din;
      end
      case (state)
        IDLE: begin
          if (phi2_p && !cpu_cs_n) begin
            cia_cs_n  <= 1'b0;
            cia_rw    <= cpu_rw;
            cia_rs    <= cpu_rs;
            cia_db_in <= cpu_din;
            state     <= CPU_SLOT;
          end else if (phi2_p && pend) begin
            cia_cs_n  <= 1'b0;
            cia_rw    <= ~h_we;
            cia_rs    <= h_rs;
            cia_db_in <= h_din;
            state     <= HOST_SLOT;
          end
        end
        CPU_SLOT, HOST_SLOT: begin
          if (fall_seen) begin
            fall_seen <= 1'b0;
            cia_cs_n  <= 1'b1;
            if (state == CPU_SLOT) cpu_dout <= cia_db_out;
            state <= (state == CPU_SLOT) ? IDLE : HOST_CAPT;
          end else if (phi2_n && !phi2_p) begin
            fall_seen <= 1'b1;
          end
        end
        HOST_CAPT: begin
          if (!h_we) host_dout <= cia_db_out;
          host_ack <= 1'b1;
          host_err <= 1'b0;
          pend     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cia_bus_arbiter.sv
// tb_cia_bus_arbiter: randomized and directed checks of the CIA arbiter against a slot-timing model
module tb_cia_bus_arbiter;
  logic       clk = 1'b0;
  logic       res_n;
  logic       phi2_p, phi2_n;
  logic       cpu_cs_n, cpu_rw;
  logic [3:0] cpu_rs;
  logic [7:0] cpu_din, cpu_dout;
  logic       host_req, host_we;
  logic [3:0] host_rs;
  logic [7:0] host_din, host_dout;
  logic       host_ack, host_err;
  logic       cia_cs_n, cia_rw;
  logic [3:0] cia_rs;
  logic [7:0] cia_db_in, cia_db_out;

  cia_bus_arbiter dut (
    .clk(clk), .res_n(res_n), .phi2_p(phi2_p), .phi2_n(phi2_n),
    .cpu_cs_n(cpu_cs_n), .cpu_rw(cpu_rw), .cpu_rs(cpu_rs), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .host_req(host_req), .host_we(host_we), .host_rs(host_rs), .host_din(host_din),
    .host_dout(host_dout), .host_ack(host_ack), .host_err(host_err),
    .cia_cs_n(cia_cs_n), .cia_rw(cia_rw), .cia_rs(cia_rs), .cia_db_in(cia_db_in), .cia_db_out(cia_db_out)
  );

  always #5 clk = ~clk;

  // simple CIA: register file sampled at phi2_n, ICR clears on read, PRB reads counted as pc_n strobes
  logic [7:0] cia_regs [16];
  logic       cia_load;
  int         pc_reads;
  always @(posedge clk) begin
    if (cia_load) begin
      for (int i = 0; i < 16; i++) cia_regs[i] <= 8'h00;
      cia_regs[4]  <= 8'h34;
      cia_regs[5]  <= 8'h12;
      cia_regs[13] <= 8'h01;
      cia_db_out   <= 8'h00;
      pc_reads     <= 0;
    end else if (phi2_n && !cia_cs_n) begin
      if (!cia_rw) cia_regs[cia_rs] <= cia_db_in;
      else begin
        cia_db_out <= cia_regs[cia_rs];
        if (cia_rs == 4'hD) cia_regs[13] <= 8'h00;
        if (cia_rs == 4'h1) pc_reads <= pc_reads + 1;
      end
    end
  end

  // phi2 has a fixed 8-clk period: rising strobe at phase 0, falling strobe at phase 4
  localparam int P = 8;
  logic [15:0] rd_blk = 16'h3902;
  logic [15:0] wr_blk = 16'h0000;
  int vectors = 0;
  int miscompares = 0;
  int e = 0;
  bit rnd = 0;
  int busy = 0;
  // behavioural model: slot owner (0 none, 1 cpu, 2 host) and the edge its phi2_p was taken
  int owner, s;
  bit capt, req_v;
  logic       rq_we;
  logic [3:0] rq_rs;
  logic [7:0] rq_din, rd;
  logic [7:0] shadow [16];
  logic       e_cs_n, e_rw, e_ack, e_err;
  logic [3:0] e_rs;
  logic [7:0] e_db, e_cpu_dout, e_host_dout;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", n, e, got, exp);
    end
  endtask

  task automatic model_reset();
    owner = 0; capt = 0; req_v = 0;
    e_cs_n = 1; e_rw = 1; e_rs = 0; e_db = 0;
    e_cpu_dout = 0; e_host_dout = 0; e_ack = 0; e_err = 0;
  endtask

  // predicts DUT outputs after the coming posedge from the current inputs
  task automatic model_edge();
    bit prev_ack, old_rv;
    if (!res_n) begin
      model_reset();
      return;
    end
    prev_ack = e_ack;
    old_rv = req_v;
    e_ack = 0;
    e_err = 0;
    if (capt) begin
      capt = 0; e_ack = 1; req_v = 0;
      if (!rq_we) e_host_dout = rd;
    end
    if (owner != 0) begin
      if (e == s + 4) begin
        if (!e_rw) shadow[e_rs] = e_db;
        else begin
          rd = shadow[e_rs];
          if (e_rs == 4'hD) shadow[13] = 8'h00;
        end
      end else if (e == s + 5) begin
        e_cs_n = 1;
        if (owner == 1) e_cpu_dout = rd; else capt = 1;
        owner = 0;
      end
    end else if (e % P == 0) begin
      if (!cpu_cs_n) begin
        owner = 1; s = e; e_cs_n = 0; e_rw = cpu_rw; e_rs = cpu_rs; e_db = cpu_din;
      end else if (old_rv) begin
        owner = 2; s = e; e_cs_n = 0; e_rw = !rq_we; e_rs = rq_rs; e_db = rq_din;
      end
    end
    if (host_req && !old_rv && !prev_ack) begin
      if (host_we ? wr_blk[host_rs] : rd_blk[host_rs]) begin
        e_ack = 1; e_err = 1;
      end else begin
        req_v = 1; rq_we = host_we; rq_rs = host_rs; rq_din = host_din;
      end
    end
  endtask

  task automatic compare();
    vectors++;
    chk("cia_cs_n", cia_cs_n, e_cs_n);
    if (!e_cs_n) begin
      chk("cia_rw", cia_rw, e_rw);
      chk("cia_rs", cia_rs, e_rs);
      chk("cia_db_in", cia_db_in, e_db);
    end
    chk("cpu_dout", cpu_dout, e_cpu_dout);
    chk("host_ack", host_ack, e_ack);
    chk("host_dout", host_dout, e_host_dout);
    if (e_ack) chk("host_err", host_err, e_err);
  endtask

  task automatic tick();
    phi2_p = (e % P == 0);
    phi2_n = (e % P == 4);
    if (!rnd) begin
      cpu_cs_n = (busy == 0);
      if (phi2_p && busy > 0) busy--;
    end
    model_edge();
    @(posedge clk);
    @(negedge clk);
    e++;
    compare();
  endtask

  task automatic align(input int ph);
    while (e % P != ph) tick();
  endtask

  task automatic host_op(input logic we, input logic [3:0] rs, input logic [7:0] din,
                         output logic [7:0] dout, output logic err, output int k);
    host_we = we; host_rs = rs; host_din = din; host_req = 1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!host_ack && k < 200);
    if (!host_ack) begin
      miscompares++;
      $display("FAIL host_op timeout: no host_ack within %0d clk, ack required", k);
    end
    dout = host_dout;
    err = host_err;
    host_req = 0;
    tick();
  endtask

  initial begin
    logic [7:0] d;
    logic er;
    int k, p0, burst, ext;
    res_n = 0; cia_load = 1;
    cpu_cs_n = 1; cpu_rw = 1; cpu_rs = 0; cpu_din = 0;
    host_req = 0; host_we = 0; host_rs = 0; host_din = 0;
    phi2_p = 0; phi2_n = 0;
    for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
    shadow[4] = 8'h34; shadow[5] = 8'h12; shadow[13] = 8'h01;
    rd = 8'h00;
    model_reset();
    tick(); tick();
    cia_load = 0;
    chk("reset cia_cs_n", cia_cs_n, 1);
    chk("reset cia_rw", cia_rw, 1);
    chk("reset cia_rs", cia_rs, 0);
    chk("reset cia_db_in", cia_db_in, 0);
    chk("reset cpu_dout", cpu_dout, 0);
    chk("reset host_ack", host_ack, 0);
    res_n = 1;
    // host read of TA lo with the CPU idle
    align(1);
    host_op(0, 4'h4, 8'h00, d, er, k);
    chk("ta_lo data", d, 8'h34);
    chk("ta_lo err", er, 0);
    chk("ta_lo latency", k, 14);
    // host write DDRA then read it back
    align(1);
    host_op(1, 4'h2, 8'hA5, d, er, k);
    chk("ddra write err", er, 0);
    host_op(0, 4'h2, 8'h00, d, er, k);
    chk("ddra readback", d, 8'hA5);
    // CPU holds the CIA for 5 phi2 cycles; host gets the 6th
    align(1);
    busy = 5;
    host_op(0, 4'h3, 8'h00, d, er, k);
    chk("cpu busy latency", k, 54);
    chk("cpu busy data", d, 8'h00);
    // refused reads: ICR and PRB complete in one clk with no bus cycle
    align(1);
    p0 = pc_reads;
    host_op(0, 4'hD, 8'h00, d, er, k);
    chk("icr err", er, 1);
    chk("icr latency", k, 1);
    host_op(0, 4'h1, 8'h00, d, er, k);
    chk("prb err", er, 1);
    chk("prb latency", k, 1);
    chk("prb pc_n strobes", pc_reads, p0);
    cpu_rs = 4'hD; busy = 1;
    for (int i = 0; i < 2 * P; i++) tick();
    chk("cpu icr read", cpu_dout, 8'h01);
    cpu_rs = 0;
    // reset in the middle of a host slot
    align(1);
    host_we = 0; host_rs = 4'h5; host_req = 1;
    for (int i = 0; i < 9; i++) tick();
    chk("host slot active", cia_cs_n, 0);
    res_n = 0;
    host_req = 0;
    #1;
    chk("async reset cs_n", cia_cs_n, 1);
    chk("async reset ack", host_ack, 0);
    model_reset();
    tick(); tick();
    res_n = 1;
    align(1);
    host_op(0, 4'h5, 8'h00, d, er, k);
    chk("post reset data", d, 8'h12);
    chk("post reset err", er, 0);
    // randomized traffic
    rnd = 1; burst = 0; ext = 0;
    for (int i = 0; i < 4000; i++) begin
      if (burst > 0) begin
        cpu_cs_n = 0;
        burst--;
      end else begin
        cpu_cs_n = 1'($urandom);
        if ($urandom_range(199, 0) == 0) burst = 48;
      end
      cpu_rw = 1'($urandom); cpu_rs = 4'($urandom); cpu_din = 8'($urandom);
      if (host_req && (host_ack || ext != 0)) begin
        if (host_ack && ext == 0 && $urandom_range(2, 0) == 0) ext = 1;
        else begin
          host_req = 0;
          ext = 0;
        end
      end else if (!host_req && $urandom_range(3, 0) == 0) begin
        host_req = 1; host_we = 1'($urandom); host_rs = 4'($urandom); host_din = 8'($urandom);
      end
      tick();
    end
    host_req = 0;
    for (int i = 0; i < 3 * P; i++) tick();
    for (int i = 0; i < 16; i++) chk($sformatf("cia reg %0d", i), cia_regs[i], shadow[i]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
